tl_demux_d: RTL

- Downstream response stage on the TileLink D channel. Takes one D-channel stream, for example the output of a slave-side arbiter, and routes each beat to one of MASTER_NUM master ports.
- The destination port is decoded from the beat's source field.
- A 2-entry internal buffer decouples the input ready from the master-side readies.
- Multi-beat AccessAckData responses are route-locked until their last beat, so the beats of one burst never interleave across ports.

---
 rtl/tl_demux_d_if.sv | 23 ++
 rtl/tl_demux_d.sv | 109 ++++++++++
 2 files changed

// File: rtl/tl_demux_d_if.sv
// rtl/tl_demux_d_if.sv - D-channel demux bus: one upstream stream, MASTER_NUM downstream ports
interface tl_demux_d_if #(
   parameter int  MASTER_NUM = 2,
   parameter type DATA_T     = logic [0:0]
) ();
   DATA_T                   inp_bits_i;
   logic                    inp_valid_i;
   logic                    inp_ready_o;
   DATA_T [MASTER_NUM-1:0]  oup_bits_o;
   logic  [MASTER_NUM-1:0]  oup_valid_o;
   logic  [MASTER_NUM-1:0]  oup_ready_i;
   logic                    route_err_o;

   modport master (
      output inp_bits_i, inp_valid_i, oup_ready_i,
      input  inp_ready_o, oup_bits_o, oup_valid_o, route_err_o
   );

   modport slave (
      input  inp_bits_i, inp_valid_i, oup_ready_i,
      output inp_ready_o, oup_bits_o, oup_valid_o, route_err_o
   );
endinterface

// File: rtl/tl_demux_d.sv
// rtl/tl_demux_d.sv - TileLink D-channel demux with 2-entry buffer and burst route lock
package tl_pkg;
   localparam logic [2:0] ACCESS_ACK      = 3'd0;
   localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

   typedef struct packed {
      logic [2:0]  opcode;
      logic [7:0]  size;
      logic [7:0]  source;
      logic [31:0] data;
   } d_beat_t;
endpackage

module tl_demux_d #(
   parameter int  MASTER_NUM = 2,
   parameter type DATA_T     = tl_pkg::d_beat_t,
   parameter int  SRC_LSB    = 0,
   parameter int  IDX_W      = $clog2(MASTER_NUM)
) (
   input  logic         clk_i,
   input  logic         rst_i,
   tl_demux_d_if.slave  bus
);
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BURST = 2'd1
   } state_e;

   state_e                 state_q, state_d;
   logic [9:0]             beat_cnt_q, beat_cnt_d;
   logic [IDX_W-1:0]       lock_idx_q, lock_idx_d;
   logic [1:0]             fill_q, fill_d;
   logic                   wr_ptr_q, rd_ptr_q;
   DATA_T                  mem_q [2];

   DATA_T                  head;
   logic                   empty, push, pop, legal;
   logic [IDX_W-1:0]       idx;
   logic [MASTER_NUM-1:0]  sel_valid;

   assign head  = mem_q[rd_ptr_q];
   assign empty = (fill_q == 2'd0);
   assign push  = bus.inp_valid_i && (fill_q != 2'd2);
   assign idx   = (state_q == ST_BURST) ? lock_idx_q : head.source[SRC_LSB +: IDX_W];
   assign legal = 32'(idx) < 32'(MASTER_NUM);

   // An out-of-range head is sunk without waiting on any ready.
   always_comb begin
      for (int p = 0; p < MASTER_NUM; p++) begin
         sel_valid[p] = !empty && legal && (32'(idx) == 32'(p));
      end
      pop    = !empty && (!legal || |(sel_valid & bus.oup_ready_i));
      fill_d = fill_q + {1'b0, push} - {1'b0, pop};
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q    <= ST_IDLE;
         beat_cnt_q <= '0;
         lock_idx_q <= '0;
         fill_q     <= 2'd0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         beat_cnt_q <= beat_cnt_d;
         lock_idx_q <= lock_idx_d;
         fill_q     <= fill_d;
         if (push) wr_ptr_q <= ~wr_ptr_q;
         if (pop)  rd_ptr_q <= ~rd_ptr_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q] <= bus.inp_bits_i;
   end

   always_comb begin
      state_d    = state_q;
      beat_cnt_d = beat_cnt_q;
      lock_idx_d = lock_idx_q;
      case (state_q)
         ST_IDLE: begin
            // The lock also captures an illegal index so the whole burst is sunk.
            if (pop && head.opcode == tl_pkg::ACCESS_ACK_DATA && head.size != '0) begin
               state_d    = ST_BURST;
               beat_cnt_d = 10'(head.size);
               lock_idx_d = idx;
            end
         end
         ST_BURST: begin
            if (pop) begin
               beat_cnt_d = beat_cnt_q - 10'd1;
               if (beat_cnt_q == 10'd1) state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.inp_ready_o = (fill_q != 2'd2);
      bus.oup_valid_o = sel_valid;
      bus.route_err_o = !empty && !legal && (state_q == ST_IDLE);
      for (int p = 0; p < MASTER_NUM; p++) begin
         bus.oup_bits_o[p] = head;
      end
   end
endmodule
